// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 encryptor.
package arc4_pkg;

    localparam int S_SIZE  = 256;
    localparam int KEY_LEN = 3;

    typedef enum logic [3:0] {
        IDLE, INIT, KSA_RDI, KSA_RDJ, KSA_WRI, KSA_WRJ, RD_LEN,
        PRGA_RDI, PRGA_RDJ, PRGA_WRI, PRGA_WRJ, PRGA_RDK, PT_RD, CT_WR, DONE
    } state_t;

    // Byte idx mod 3 of the key, most significant byte first.
    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [7:0] idx);
        logic [1:0] m;
        m = 2'(idx % 8'(KEY_LEN));
        return m == 2'd0 ? key[23:16] : m == 2'd1 ? key[15:8] : key[7:0];
    endfunction

endpackage

// File: rtl/s_mem.sv
// s_mem: 256x8 single-port RAM with registered read, holds the ARC4 S array.
module s_mem
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic       we_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem [S_SIZE];

    always_ff @(posedge clk) begin
        if (we_i) mem[addr_i] <= wdata_i;
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: encrypts a length-prefixed plaintext buffer with ARC4 (24-bit key).
// S lives in s_mem; all control and data registers sit in one FSM block.
module arc4_encrypt
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren
);

    state_t      state_q;
    logic [23:0] key_q;
    logic [7:0]  i_q, j_q, len_q, si_q, sj_q;
    logic [8:0]  k_q;
    logic        rdy_q, ct_wren_q;
    logic [7:0]  pt_addr_q, ct_addr_q, ct_wrdata_q;
    logic [7:0]  j_d, s_addr, s_wdata, s_rdata;
    logic        s_we, rd_j, wr_j;

    assign rdy       = rdy_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;

    // The RAM address is combinational so each read result lands in the following state.
    always_comb begin
        rd_j    = state_q == KSA_RDJ || state_q == PRGA_RDJ;
        wr_j    = state_q == KSA_WRJ || state_q == PRGA_WRJ;
        j_d     = j_q + s_rdata + (state_q == KSA_RDJ ? key_byte(key_q, i_q) : 8'd0);
        s_addr  = rd_j ? j_d : wr_j ? j_q : state_q == PRGA_RDK ? si_q + sj_q : i_q;
        s_we    = state_q inside {INIT, KSA_WRI, KSA_WRJ, PRGA_WRI, PRGA_WRJ};
        s_wdata = state_q == INIT ? i_q : wr_j ? si_q : s_rdata;
    end

    s_mem u_s_mem (
        .clk     (clk),
        .addr_i  (s_addr),
        .wdata_i (s_wdata),
        .we_i    (s_we),
        .rdata_o (s_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            len_q       <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            rdy_q       <= 1'b1;
            pt_addr_q   <= '0;
            ct_addr_q   <= '0;
            ct_wrdata_q <= '0;
            ct_wren_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (en) begin
                        state_q   <= INIT;
                        key_q     <= key;
                        i_q       <= '0;
                        j_q       <= '0;
                        k_q       <= '0;
                        pt_addr_q <= '0;
                        rdy_q     <= 1'b0;
                    end
                end
                INIT: begin
                    i_q <= i_q + 8'd1;
                    j_q <= '0;
                    if (i_q == 8'd255) state_q <= KSA_RDI;
                end
                KSA_RDI:  state_q <= KSA_RDJ;
                PRGA_RDI: state_q <= PRGA_RDJ;
                KSA_RDJ, PRGA_RDJ: begin
                    si_q    <= s_rdata;
                    j_q     <= j_d;
                    state_q <= state_q == KSA_RDJ ? KSA_WRI : PRGA_WRI;
                end
                KSA_WRI, PRGA_WRI: begin
                    sj_q    <= s_rdata;
                    state_q <= state_q == KSA_WRI ? KSA_WRJ : PRGA_WRJ;
                end
                KSA_WRJ: begin
                    i_q     <= i_q + 8'd1;
                    state_q <= KSA_RDI;
                    // pt_addr has held 0 throughout, so the length byte is already on pt_rddata.
                    if (i_q == 8'd255) begin
                        j_q         <= '0;
                        len_q       <= pt_rddata;
                        ct_addr_q   <= '0;
                        ct_wrdata_q <= pt_rddata;
                        ct_wren_q   <= 1'b1;
                        state_q     <= RD_LEN;
                    end
                end
                RD_LEN: begin
                    ct_wren_q <= 1'b0;
                    if (len_q == 8'd0) begin
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        i_q     <= i_q + 8'd1;
                        k_q     <= 9'd1;
                        state_q <= PRGA_RDI;
                    end
                end
                PRGA_WRJ: begin
                    pt_addr_q <= k_q[7:0];
                    state_q   <= PRGA_RDK;
                end
                PRGA_RDK: state_q <= PT_RD;
                PT_RD: begin
                    ct_addr_q   <= k_q[7:0];
                    ct_wrdata_q <= pt_rddata ^ s_rdata;
                    ct_wren_q   <= 1'b1;
                    state_q     <= CT_WR;
                end
                CT_WR: begin
                    ct_wren_q <= 1'b0;
                    if (k_q == {1'b0, len_q}) begin
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q     <= k_q + 9'd1;
                        i_q     <= i_q + 8'd1;
                        state_q <= PRGA_RDI;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: directed vectors for arc4_encrypt; expected ct writes are queued
// by the stimulus and consumed by an independent write monitor.
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rdy;
    logic [23:0] key = '0;
    logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;
    logic        ct_wren;

    typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t e;

    logic [7:0] pt_mem [256];
    logic [7:0] exp_ct [256];
    logic [7:0] ks_ref [256];
    logic [7:0] pt029 [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ct029 [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    arc4_encrypt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

    always @(negedge clk) begin
        if (rst_n && ct_wren) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%02h data=%02h", ct_addr, ct_wrdata);
            end else begin
                e = exp_q.pop_front();
                if (ct_addr !== e.a || ct_wrdata !== e.d) begin
                    errors++;
                    $display("FAIL ct_write got addr=%02h data=%02h exp addr=%02h data=%02h",
                             ct_addr, ct_wrdata, e.a, e.d);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Plain software ARC4 used only for the long keystream vector.
    task automatic gen_ks(input logic [23:0] k, input int n);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] t, i, j;
        kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = j + s[a] + kb[a % 3];
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int a = 1; a <= n; a++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks_ref[a] = s[8'(s[i] + s[j])];
        end
    endtask

    task automatic start(input logic [23:0] k);
        int n = 0;
        @(negedge clk);
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        en = 1'b1;
        key = k;
        @(negedge clk);
        en = 1'b0;
        check("rdy_low_after_start", rdy, 0);
    endtask

    task automatic wait_done(input int n_exp);
        int n = 0;
        logic last = 1'b0;
        while (!rdy && n < 6000) begin
            last = ct_wren;
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL run_timeout rdy=%0b after %0d cycles", rdy, n);
        end
        check("rdy_after_last_write", last, 1);
        #1;
        check("write_count", wr_cnt, n_exp);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run(input logic [23:0] k, input int len);
        for (int a = 0; a <= len; a++) exp_q.push_back('{8'(a), exp_ct[a]});
        wr_cnt = 0;
        start(k);
        wait_done(len + 1);
    endtask

    task automatic load_029();
        for (int a = 0; a < 256; a++) pt_mem[a] = 8'hA5;
        for (int a = 0; a < 10; a++) begin
            pt_mem[a] = pt029[a];
            exp_ct[a] = ct029[a];
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rdy", rdy, 1);
        check("reset_ct_wren", ct_wren, 0);
        check("reset_ct_addr", ct_addr, 0);
        check("reset_ct_wrdata", ct_wrdata, 0);
        check("reset_pt_addr", pt_addr, 0);
        rst_n = 1'b1;

        load_029();
        run(24'h4B6579, 9);

        for (int a = 0; a < 256; a++) pt_mem[a] = 8'h33;
        pt_mem[0] = 8'h00;
        exp_ct[0] = 8'h00;
        run(24'h123456, 0);

        for (int a = 0; a < 10; a++) begin
            pt_mem[a] = ct029[a];
            exp_ct[a] = pt029[a];
        end
        run(24'h4B6579, 9);

        // en pulse mid-KSA must be ignored and must not queue a second run.
        load_029();
        for (int a = 0; a <= 9; a++) exp_q.push_back('{8'(a), exp_ct[a]});
        wr_cnt = 0;
        start(24'h4B6579);
        repeat (300) @(negedge clk);
        en = 1'b1;
        key = 24'hFFFFFF;
        @(negedge clk);
        en = 1'b0;
        check("rdy_low_mid_ksa", rdy, 0);
        wait_done(10);
        repeat (100) @(negedge clk);
        check("no_second_run_rdy", rdy, 1);
        check("no_second_run_writes", wr_cnt, 10);

        // Asynchronous reset mid-PRGA.
        load_029();
        for (int a = 0; a <= 9; a++) exp_q.push_back('{8'(a), exp_ct[a]});
        wr_cnt = 0;
        start(24'h4B6579);
        begin
            int n = 0;
            while (!(ct_wren && ct_addr == 8'd3) && n < 6000) begin
                @(negedge clk);
                n++;
            end
            check("reached_mid_prga", {ct_wren, ct_addr}, {1'b1, 8'd3});
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrun_reset_rdy", rdy, 1);
        check("midrun_reset_ct_wren", ct_wren, 0);
        check("midrun_reset_ct_addr", ct_addr, 0);
        check("midrun_reset_pt_addr", pt_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr_cnt = 0;
        repeat (300) @(negedge clk);
        check("post_reset_idle_rdy", rdy, 1);
        check("post_reset_no_writes", wr_cnt, 0);
        run(24'h4B6579, 9);

        // Maximum length with an all-zero key.
        gen_ks(24'h000000, 255);
        pt_mem[0] = 8'd255;
        exp_ct[0] = 8'd255;
        for (int a = 1; a < 256; a++) begin
            pt_mem[a] = 8'h00;
            exp_ct[a] = ks_ref[a];
        end
        run(24'h000000, 255);
        repeat (20) @(negedge clk);
        check("no_write_past_255", wr_cnt, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arc4_encrypt.md
ARC4_ENCRYPT -- requirements
Module: arc4_encrypt

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 en  in  1  start request; sampled only while rdy=1.
REQ-004 rdy  out  1  high = idle and able to accept en.
REQ-005 key  in  24  ARC4 key, sampled with en; key byte k mod 3: 0->key[23:16], 1->key[15:8], 2->key[7:0].
REQ-006 pt_addr  out  8  plaintext source address; the source is length-prefixed, with pt[0] = length L.
REQ-007 pt_rddata  in  8  plaintext data, valid one cycle after pt_addr (synchronous read).
REQ-008 ct_addr  out  8  ciphertext memory address.
REQ-009 ct_wrdata  out  8  ciphertext write data.
REQ-010 ct_wren  out  1  ciphertext write strobe; exactly one byte is written per asserted cycle.

Function
REQ-011 Output image: ct[0] = L unencrypted; ct[k] = pt[k] XOR keystream byte k, for k = 1..L; no other ct address is written.
REQ-012 Handshake: a cycle with en=1 and rdy=1 latches key and starts a run; rdy=0 from the next cycle until the run completes; rdy=1 on the cycle after the last ct write.
REQ-013 en while rdy=0 is ignored; no queuing.
REQ-014 S array is a 256x8 synchronous-read RAM with 1-cycle read latency, internal to the block.
REQ-015 States in order: IDLE, INIT, KSA_RDI, KSA_RDJ, KSA_WRI, KSA_WRJ, RD_LEN, PRGA_RDI, PRGA_RDJ, PRGA_WRI, PRGA_WRJ, PRGA_RDK, PT_RD, CT_WR, DONE; DONE returns to IDLE.
REQ-016 INIT: S[i]=i for i = 0..255, one write per cycle (256 cycles).
REQ-017 KSA: for i = 0..255, j = (j + S[i] + keybyte[i mod 3]) mod 256, then swap S[i] and S[j] with two writes; all arithmetic is 8-bit wrap.
REQ-018 RD_LEN: read pt[0], write ct[0]=L; if L=0, go to DONE with no further writes.
REQ-019 PRGA, for k = 1..L: i=(i+1) mod 256; j=(j+S[i]) mod 256; swap S[i] and S[j]; pad=S[(S[i]+S[j]) mod 256]; read pt[k]; write ct[k]=pt[k]^pad.
REQ-020 The swap uses the S[i] and S[j] values held in registers before the swap; a read-after-write to the same address (i==j) returns the written value.
REQ-021 i and j are cleared to 0 at the start of KSA and again at the start of PRGA.
REQ-022 L=255 is legal; the k counter is 9 bits wide or uses equality-terminated compare, so it does not wrap before k=L.
REQ-023 Each run re-executes INIT; no S state carries over between runs.
REQ-024 ct_wren=0 in every state other than RD_LEN and CT_WR.

Reset
REQ-025 On rst_n=0: state=IDLE, rdy=1, ct_wren=0, ct_addr=0, ct_wrdata=0, pt_addr=0, i=j=k=0; takes effect immediately, including mid-run.
REQ-026 After reset mid-run, no ct write occurs until a new en is accepted.

Structure
REQ-027 A shared package arc4_pkg holds the state enum typedef, the S size constant (256), and the key length constant (3).
REQ-028 One sub-module, s_mem (256x8 single-port synchronous RAM), is instantiated for S; all other logic is in arc4_encrypt.

Verification
REQ-029 key=24'h4B6579, pt={9,"Plaintext"} -> ct = 09 BB F3 16 E8 D9 40 AF 0A D3, and rdy returns high.
REQ-030 L=0, any key -> exactly one write, ct[0]=00, then rdy=1.
REQ-031 Round trip: the output of REQ-029 fed back as pt with the same key -> ct = {9,"Plaintext"}.
REQ-032 en pulsed while rdy=0 (mid-KSA) -> output is identical to REQ-029, and only one run occurs.
REQ-033 rst_n pulsed low mid-PRGA -> rdy=1 immediately, no further ct_wren; a subsequent run of REQ-029 produces the correct ct.
REQ-034 L=255 of pt=00 with key=24'h000000 -> 256 writes, the last at ct_addr=255, ct[1..255] equal to the reference keystream, and no write beyond address 255.
